// File: rtl/axis_dma_s2mm_arbiter_if.sv
// Stream bundle around the S2MM arbiter: NUM_SRC packed source ports in, one DMA-side port out.
// master = arbiter view, slave = surrounding sources/DMA view.
interface axis_dma_s2mm_arbiter_if #(
  parameter int TDATA_WIDTH = 128,
  parameter int NUM_SRC     = 4
);
  logic [NUM_SRC*TDATA_WIDTH-1:0]   S_AXIS_TDATA;
  logic [NUM_SRC*TDATA_WIDTH/8-1:0] S_AXIS_TKEEP;
  logic [NUM_SRC-1:0]               S_AXIS_TVALID;
  logic [NUM_SRC-1:0]               S_AXIS_TLAST;
  logic [NUM_SRC-1:0]               S_AXIS_TREADY;
  logic [TDATA_WIDTH-1:0]           M_AXIS_TDATA;
  logic [TDATA_WIDTH/8-1:0]         M_AXIS_TKEEP;
  logic                             M_AXIS_TVALID;
  logic                             M_AXIS_TLAST;
  logic                             M_AXIS_TREADY;

  modport master (
    input  S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TVALID, S_AXIS_TLAST, M_AXIS_TREADY,
    output S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TVALID, M_AXIS_TLAST
  );

  modport slave (
    output S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TVALID, S_AXIS_TLAST, M_AXIS_TREADY,
    input  S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TVALID, M_AXIS_TLAST
  );
endinterface

// File: rtl/axis_dma_s2mm_arbiter.sv
// Packet round-robin sharing of one DMA S2MM stream; WAIT_INTR timeout under AXIS_DMA_ARB_INTR_TIMEOUT_EN.
// Grant costs one cycle, then zero-latency pass-through; only the granted source sees M_AXIS_TREADY.
module axis_dma_s2mm_arbiter #(
  parameter int TDATA_WIDTH = 128,
  parameter int NUM_SRC     = 4,
  parameter int SRC_ID_W    = 3
`ifdef AXIS_DMA_ARB_INTR_TIMEOUT_EN
  , parameter int INTR_TIMEOUT = 65535
`endif
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  axis_dma_s2mm_arbiter_if.master axis,
  input  logic                    AXIDMA_S2MM_INTR_IN,
  output logic [SRC_ID_W-1:0]     GRANT_ID,
`ifdef AXIS_DMA_ARB_INTR_TIMEOUT_EN
  output logic                    TIMEOUT_ERR,
`endif
  output logic                    BUSY
);
  localparam int KEEP_W = TDATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, WAIT_INTR = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [SRC_ID_W-1:0]   grant_q, grant_d, rr_ptr_q, rr_ptr_d, winner;
  logic                  any_req, intr_q, intr_fall, pkt_end;
  logic [TDATA_WIDTH-1:0] sel_dat;
  logic [KEEP_W-1:0]     sel_keep;
  logic                  sel_vld, sel_last;

  assign intr_fall = intr_q & ~AXIDMA_S2MM_INTR_IN;
  assign pkt_end   = (state_q == STREAM) & sel_vld & axis.M_AXIS_TREADY & sel_last;

`ifdef AXIS_DMA_ARB_INTR_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_hit;

  // Counter sits at zero outside WAIT_INTR, so it is already clear on entry.
  assign tmo_hit = (state_q == WAIT_INTR) & (tmo_cnt_q == 16'(INTR_TIMEOUT)) & ~intr_fall;

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == WAIT_INTR) begin
      tmo_cnt_d = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
    end
  end
`endif

  // Lowest index above rr_ptr wins; otherwise wrap to the lowest index at or below it.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (axis.S_AXIS_TVALID[i] && (SRC_ID_W'(i) <= rr_ptr_q)) begin
        winner  = SRC_ID_W'(i);
        any_req = 1'b1;
      end
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (axis.S_AXIS_TVALID[i] && (SRC_ID_W'(i) > rr_ptr_q)) begin
        winner  = SRC_ID_W'(i);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    sel_dat  = '0;
    sel_keep = '0;
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == SRC_ID_W'(i)) begin
        sel_dat  = axis.S_AXIS_TDATA[i*TDATA_WIDTH +: TDATA_WIDTH];
        sel_keep = axis.S_AXIS_TKEEP[i*KEEP_W +: KEEP_W];
        sel_vld  = axis.S_AXIS_TVALID[i];
        sel_last = axis.S_AXIS_TLAST[i];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= SRC_ID_W'(NUM_SRC - 1);
      intr_q    <= 1'b0;
`ifdef AXIS_DMA_ARB_INTR_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      intr_q    <= AXIDMA_S2MM_INTR_IN;
`ifdef AXIS_DMA_ARB_INTR_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (pkt_end) begin
          rr_ptr_d = grant_q;
          state_d  = WAIT_INTR;
        end
      end
      WAIT_INTR: begin
        if (intr_fall) state_d = IDLE;
`ifdef AXIS_DMA_ARB_INTR_TIMEOUT_EN
        else if (tmo_hit) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    axis.M_AXIS_TDATA  = sel_dat;
    axis.M_AXIS_TKEEP  = sel_keep;
    axis.M_AXIS_TVALID = 1'b0;
    axis.M_AXIS_TLAST  = 1'b0;
    axis.S_AXIS_TREADY = '0;
    if (state_q == STREAM) begin
      axis.M_AXIS_TVALID = sel_vld;
      axis.M_AXIS_TLAST  = sel_last;
      for (int i = 0; i < NUM_SRC; i++) begin
        axis.S_AXIS_TREADY[i] = (grant_q == SRC_ID_W'(i)) & axis.M_AXIS_TREADY;
      end
    end
    GRANT_ID = grant_q;
    BUSY     = (state_q != IDLE);
`ifdef AXIS_DMA_ARB_INTR_TIMEOUT_EN
    TIMEOUT_ERR = tmo_hit;
`endif
  end
endmodule

// File: tb/tb_axis_dma_s2mm_arbiter.sv
// Directed bench for axis_dma_s2mm_arbiter: bench-side source model, per-beat scoreboard, ordered packet log.
// Timeout scenario runs only when AXIS_DMA_ARB_INTR_TIMEOUT_EN is defined.
module tb_axis_dma_s2mm_arbiter;
  localparam int TW = 32;
  localparam int NS = 4;
  localparam int IW = 3;
  localparam int KW = TW / 8;
`ifdef AXIS_DMA_ARB_INTR_TIMEOUT_EN
  localparam int T3_HOLD = 12;
`else
  localparam int T3_HOLD = 20;
`endif

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          intr = 1'b0;
  logic [IW-1:0] GRANT_ID;
  logic          BUSY;
`ifdef AXIS_DMA_ARB_INTR_TIMEOUT_EN
  logic          TIMEOUT_ERR;
`endif

  axis_dma_s2mm_arbiter_if #(.TDATA_WIDTH(TW), .NUM_SRC(NS)) axis ();

  axis_dma_s2mm_arbiter #(
    .TDATA_WIDTH (TW),
    .NUM_SRC     (NS),
    .SRC_ID_W    (IW)
`ifdef AXIS_DMA_ARB_INTR_TIMEOUT_EN
    , .INTR_TIMEOUT(16)
`endif
  ) dut (
    .ACLK                (ACLK),
    .ARESETN             (ARESETN),
    .axis                (axis),
    .AXIDMA_S2MM_INTR_IN (intr),
    .GRANT_ID            (GRANT_ID),
`ifdef AXIS_DMA_ARB_INTR_TIMEOUT_EN
    .TIMEOUT_ERR         (TIMEOUT_ERR),
`endif
    .BUSY                (BUSY)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;
  logic [NS-1:0] act, hs;
  int len [NS];
  int npk [NS];
  int beat [NS];
  int pkt [NS];
  int timer = 0;
  bit auto_intr = 1'b0;
  bit rdy_toggle = 1'b0;
  logic m_rdy = 1'b1;
  int bub_src = -1;
  int bub_beat = 0;
  int bub_left = 0;
  int done_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] dat(input int s, input int p, input int b);
    return {8'(s), 8'(p), 8'(b), 8'hA5};
  endfunction

  function automatic logic [KW-1:0] kp(input int b);
    logic [KW-1:0] f;
    f = '1;
    return f >> (b % KW);
  endfunction

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      logic v;
      v = act[i];
      if (i == bub_src && beat[i] == bub_beat && bub_left > 0 && act[i]) begin
        v = 1'b0;
        bub_left--;
      end
      axis.S_AXIS_TVALID[i]         = v;
      axis.S_AXIS_TLAST[i]          = act[i] && (beat[i] == len[i] - 1);
      axis.S_AXIS_TDATA[i*TW +: TW] = dat(i, pkt[i], beat[i]);
      axis.S_AXIS_TKEEP[i*KW +: KW] = kp(beat[i]);
    end
    if (rdy_toggle) m_rdy = ~m_rdy;
    axis.M_AXIS_TREADY = m_rdy;
  endtask

  // One clock: retire last cycle's handshakes, drive, then score this cycle's transfers.
  task automatic tick();
    @(posedge ACLK); #1;
    for (int i = 0; i < NS; i++) begin
      if (hs[i]) begin
        if (beat[i] == len[i] - 1) begin
          done_q.push_back(i);
          beat[i] = 0;
          pkt[i]++;
          if (pkt[i] == npk[i]) act[i] = 1'b0;
          if (auto_intr) timer = 6;
        end else begin
          beat[i]++;
        end
      end
    end
    if (timer > 0) timer--;
    if (auto_intr) intr = (timer == 1 || timer == 2);
    drive();
    #1;
    hs = axis.S_AXIS_TVALID & axis.S_AXIS_TREADY;
    chk("tready_onehot", 64'($onehot0(axis.S_AXIS_TREADY)), 64'd1);
    chk("tready_unrequested", axis.S_AXIS_TREADY & ~act, 0);
    chk("xfer_match", axis.M_AXIS_TVALID & axis.M_AXIS_TREADY, |hs);
    for (int i = 0; i < NS; i++) begin
      if (hs[i]) begin
        chk("beat_grant", GRANT_ID, i);
        chk("beat_data", axis.M_AXIS_TDATA, dat(i, pkt[i], beat[i]));
        chk("beat_keep", axis.M_AXIS_TKEEP, kp(beat[i]));
        chk("beat_last", axis.M_AXIS_TLAST, beat[i] == len[i] - 1);
      end
    end
  endtask

  task automatic run_pkts(input string tag, input int budget);
    int n = 0;
    while (act != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_pkts_done"}, act, 0);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((BUSY !== 1'b0 || timer != 0) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, BUSY, 0);
  endtask

  task automatic chk_order(input string tag, input int n, input int e [4]);
    chk({tag, "_count"}, done_q.size(), n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_order%0d", tag, k), (k < done_q.size()) ? done_q[k] : -1, e[k]);
    end
  endtask

  task automatic setup_src(input int s, input int l, input int np);
    len[s] = l;
    npk[s] = np;
    pkt[s] = 0;
    beat[s] = 0;
    act[s] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    act = '0;
    hs = '0;
    for (int i = 0; i < NS; i++) begin
      len[i] = 1; npk[i] = 1; beat[i] = 0; pkt[i] = 0;
    end
    drive();

    // Reset state
    #12;
    chk("rst_tready", axis.S_AXIS_TREADY, 0);
    chk("rst_mvalid", axis.M_AXIS_TVALID, 0);
    chk("rst_mlast", axis.M_AXIS_TLAST, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_grant", GRANT_ID, 0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    tick();
    tick();
    chk("idle_no_req_busy", BUSY, 0);

    // 1: sources 0 and 2 alternate, 3-beat packets
    auto_intr = 1'b1;
    done_q.delete();
    setup_src(0, 3, 2);
    setup_src(2, 3, 2);
    tick();
    chk("t1_decide_tready", axis.S_AXIS_TREADY, 0);
    chk("t1_decide_busy", BUSY, 0);
    tick();
    chk("t1_first_beat", hs, 4'b0001);
    chk("t1_first_grant", GRANT_ID, 0);
    run_pkts("t1", 200);
    drain("t1", 50);
    chk_order("t1", 4, '{0, 2, 0, 2});

    // 2: toggling ready plus a 2-cycle valid bubble from source 1
    done_q.delete();
    setup_src(1, 4, 1);
    bub_src = 1; bub_beat = 2; bub_left = 2;
    rdy_toggle = 1'b1; m_rdy = 1'b0;
    run_pkts("t2", 100);
    rdy_toggle = 1'b0; m_rdy = 1'b1; bub_src = -1;
    drain("t2", 50);
    chk_order("t2", 1, '{1, 0, 0, 0});

    // 3: interrupt held high while source 3 waits
    auto_intr = 1'b0;
    done_q.delete();
    setup_src(1, 1, 1);
    run_pkts("t3a", 20);
    setup_src(3, 2, 1);
    intr = 1'b1;
    for (int k = 0; k < T3_HOLD; k++) begin
      tick();
      chk("t3_hold_tready", axis.S_AXIS_TREADY, 0);
      chk("t3_hold_busy", BUSY, 1);
    end
    intr = 1'b0;
    tick();
    chk("t3_idle_after_fall", BUSY, 0);
    chk("t3_idle_tready", axis.S_AXIS_TREADY, 0);
    tick();
    chk("t3_grant3", GRANT_ID, 3);
    chk("t3_tready3", axis.S_AXIS_TREADY, 4'b1000);
    auto_intr = 1'b1;
    run_pkts("t3b", 20);
    drain("t3", 50);
    chk_order("t3", 2, '{1, 3, 0, 0});

    // 4: falls in IDLE and STREAM are ignored
    auto_intr = 1'b0;
    done_q.delete();
    intr = 1'b1;
    tick();
    intr = 1'b0;
    tick();
    chk("t4_idle_fall_busy", BUSY, 0);
    setup_src(0, 3, 1);
    tick();
    tick();
    intr = 1'b1;
    tick();
    intr = 1'b0;
    run_pkts("t4a", 20);
    setup_src(2, 1, 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t4_wait_busy", BUSY, 1);
      chk("t4_wait_tready", axis.S_AXIS_TREADY, 0);
    end
    intr = 1'b1;
    tick();
    intr = 1'b0;
    tick();
    chk("t4_idle_after_fall", BUSY, 0);
    tick();
    chk("t4_grant2", GRANT_ID, 2);
    auto_intr = 1'b1;
    run_pkts("t4b", 20);
    drain("t4", 50);
    chk_order("t4", 2, '{0, 2, 0, 0});

    // 5: reset mid-packet, then all four request
    done_q.delete();
    setup_src(2, 4, 1);
    tick();
    tick();
    tick();
    chk("t5_midpkt_beat", hs, 4'b0100);
    ARESETN = 1'b0;
    #1;
    chk("t5_rst_mvalid", axis.M_AXIS_TVALID, 0);
    chk("t5_rst_mlast", axis.M_AXIS_TLAST, 0);
    chk("t5_rst_tready", axis.S_AXIS_TREADY, 0);
    chk("t5_rst_busy", BUSY, 0);
    chk("t5_rst_grant", GRANT_ID, 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge ACLK); #1;
      chk("t5_rst_hold_tready", axis.S_AXIS_TREADY, 0);
    end
    hs = '0;
    timer = 0;
    intr = 1'b0;
    done_q.delete();
    for (int i = 0; i < NS; i++) setup_src(i, 1, 1);
    drive();
    ARESETN = 1'b1;
    run_pkts("t5", 200);
    drain("t5", 50);
    chk_order("t5", 4, '{0, 1, 2, 3});

`ifdef AXIS_DMA_ARB_INTR_TIMEOUT_EN
    // 6: no interrupt, timeout releases the channel
    auto_intr = 1'b0;
    done_q.delete();
    setup_src(1, 1, 1);
    run_pkts("t6a", 20);
    chk("t6_entry_tmo", TIMEOUT_ERR, 0);
    setup_src(3, 1, 1);
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("t6_wait_tmo", TIMEOUT_ERR, 0);
      chk("t6_wait_busy", BUSY, 1);
    end
    tick();
    chk("t6_pulse", TIMEOUT_ERR, 1);
    tick();
    chk("t6_pulse_end", TIMEOUT_ERR, 0);
    chk("t6_idle", BUSY, 0);
    tick();
    chk("t6_next_grant", GRANT_ID, 3);
    chk("t6_next_busy", BUSY, 1);
    auto_intr = 1'b1;
    run_pkts("t6b", 20);
    drain("t6", 50);
    chk_order("t6", 2, '{1, 3, 0, 0});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_dma_s2mm_arbiter.md
Name: axis_dma_s2mm_arbiter

Overview:
Shares one AXI DMA S2MM channel between NUM_SRC AXI-Stream packet sources. Arbitration is packet-granular round-robin. After a packet's TLAST is accepted, the block holds the channel until the DMA completion interrupt is seen, then re-arbitrates. It sits between the per-source frame builders and the axi_dma_connector/S2MM input, and supplies the grant ID to the software-visible status logic.

Parameters:
TDATA_WIDTH, 128, AXIS data width in bits; multiple of 8.
NUM_SRC, 4, number of requesters; legal range 2..8.
SRC_ID_W, 3, width of GRANT_ID; must satisfy 2**SRC_ID_W >= NUM_SRC.
INTR_TIMEOUT, 65535, cycles to wait in WAIT_INTR before forced release; used only with the optional feature.

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
S_AXIS_TDATA  in  NUM_SRC*TDATA_WIDTH  source data; source i occupies slice [i*TDATA_WIDTH +: TDATA_WIDTH]
S_AXIS_TKEEP  in  NUM_SRC*TDATA_WIDTH/8  source byte keeps, sliced the same way
S_AXIS_TVALID  in  NUM_SRC  per-source valid; also the request line
S_AXIS_TLAST  in  NUM_SRC  per-source last
S_AXIS_TREADY  out  NUM_SRC  per-source ready
M_AXIS_TDATA  out  TDATA_WIDTH  data to the DMA path
M_AXIS_TKEEP  out  TDATA_WIDTH/8  keep to the DMA path
M_AXIS_TVALID  out  1  valid to the DMA path
M_AXIS_TLAST  out  1  last to the DMA path
M_AXIS_TREADY  in  1  ready from the DMA path
AXIDMA_S2MM_INTR_IN  in  1  S2MM interrupt, level, synchronous to ACLK
GRANT_ID  out  SRC_ID_W  index of the source currently or most recently granted
BUSY  out  1  high in STREAM and WAIT_INTR

Behaviour:
Reset values (asynchronous, ARESETN low):
- state = IDLE; GRANT_ID = 0; rr_ptr = NUM_SRC-1, so source 0 has first priority.
- intr_d = 0; all S_AXIS_TREADY = 0; M_AXIS_TVALID = 0; M_AXIS_TLAST = 0; BUSY = 0.

Interrupt edge detect:
- intr_d is a register of AXIDMA_S2MM_INTR_IN.
- intr_fall = intr_d & ~AXIDMA_S2MM_INTR_IN.
- intr_fall is acted on only in WAIT_INTR; in any other state it is ignored.

State IDLE:
- Requesters are the sources with S_AXIS_TVALID high.
- Winner = first requester scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC.
- If any requester exists: GRANT_ID <= winner, state <= STREAM.
- If none exists, stay in IDLE.
- Nothing is accepted from any source in IDLE; the grant decision costs exactly one cycle.

State STREAM (combinational pass-through for the granted source g):
- M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TVALID and M_AXIS_TLAST follow source g.
- S_AXIS_TREADY[g] = M_AXIS_TREADY; every other TREADY bit = 0.
- Zero added latency.
- On a beat where M_AXIS_TVALID, M_AXIS_TREADY and M_AXIS_TLAST are all high: rr_ptr <= g, state <= WAIT_INTR.
- Source g deasserting TVALID mid-packet is a legal bubble; the grant is held.

State WAIT_INTR:
- M_AXIS_TVALID = 0 and all S_AXIS_TREADY = 0.
- On intr_fall: state <= IDLE.

Outside STREAM:
- M_AXIS_TVALID = 0 and M_AXIS_TLAST = 0.
- M_AXIS_TDATA and M_AXIS_TKEEP are don't-care but remain muxed from GRANT_ID.

Boundary conditions:
- Single requester: it is re-granted every round.
- Requests arriving during STREAM or WAIT_INTR wait; no request is lost, because sources hold TVALID per AXIS rules.
- A one-beat packet (TLAST on the first beat) goes STREAM -> WAIT_INTR after that one beat.
- A reset mid-packet abandons the packet and gives no TREADY to any source while ARESETN is low.

Optional Feature:
Macro AXIS_DMA_ARB_INTR_TIMEOUT_EN.

Defined:
- A 16-bit saturating counter clears on entry to WAIT_INTR and increments each cycle in WAIT_INTR.
- When it reaches INTR_TIMEOUT, state <= IDLE and output port TIMEOUT_ERR (1 bit, reset 0) pulses high for exactly one cycle.
- If intr_fall and the timeout occur in the same cycle, intr_fall wins and no pulse is generated.

Undefined:
- No counter and no TIMEOUT_ERR port.
- WAIT_INTR waits indefinitely for intr_fall.

Test Plan:
1. Reset, then S_AXIS_TVALID=4'b0101, each source sending a 3-beat packet, M_AXIS_TREADY=1, intr pulsed 1->0 five cycles after each TLAST -> sources accepted in order 0, 2, 0, 2; GRANT_ID sequence 0,2,0,2; first beat accepted in the 2nd cycle after the request.
2. Source 1 sends 4 beats with M_AXIS_TREADY toggling 1,0,1,0,... and source 1 TVALID dropping for 2 cycles mid-packet -> all 4 beats delivered in order with matching TKEEP; S_AXIS_TREADY[0,2,3] stay 0 throughout.
3. After TLAST, source 3 requests while AXIDMA_S2MM_INTR_IN stays high for 20 cycles and then falls -> no TREADY to any source during those 20 cycles; IDLE on the fall; grant to source 3 one cycle later.
4. Interrupt falls while in IDLE or STREAM -> ignored; the next packet after TLAST still waits for a fresh fall.
5. ARESETN asserted on beat 2 of a 4-beat packet from source 2 -> M_AXIS_TVALID=0, S_AXIS_TREADY=0 and BUSY=0 immediately; after release, all sources requesting -> source 0 granted first.
6. With AXIS_DMA_ARB_INTR_TIMEOUT_EN and INTR_TIMEOUT=16, no interrupt -> TIMEOUT_ERR is a 1-cycle pulse 16 cycles after the WAIT_INTR entry; the next grant follows.
